// File: rtl/pi_alu_sequencer_if.sv
// Bundle between the PI sequencer, its error front-end, the shared ALU and the PWM blocks.
// No logic here: wires only, direction fixed by modport.
// master = the sequencer (drives ALU selects/controls and the PI state), slave = its environment.
interface pi_alu_sequencer_if;
    logic        go;
    logic [15:0] err_in;
    logic [15:0] dst;
    logic [2:0]  src1sel;
    logic [2:0]  src0sel;
    logic        multiply;
    logic        saturate;
    logic        mult2;
    logic        mult4;
    logic        sub;
    logic [15:0] Accum;
    logic [15:0] Pcomp;
    logic [15:0] Icomp;
    logic [15:0] Intgrl;
    logic [15:0] Error;
    logic [15:0] rht;
    logic [15:0] lft;
    logic        busy;
    logic        done;

    modport master (
        input  go, err_in, dst,
        output src1sel, src0sel, multiply, saturate, mult2, mult4, sub,
        output Accum, Pcomp, Icomp, Intgrl, Error, rht, lft, busy, done
    );

    modport slave (
        output go, err_in, dst,
        input  src1sel, src0sel, multiply, saturate, mult2, mult4, sub,
        input  Accum, Pcomp, Icomp, Intgrl, Error, rht, lft, busy, done
    );
endinterface

// File: rtl/pi_alu_sequencer.sv
// Sequences the shared ALU through one PI update per accepted go; FWD/PTERM/ITERM live in the ALU source mux.
// Latency: go accepted at edge T0, steps in T1..T9, done pulse (rht/lft valid) in T10.
// No backpressure: go is only sampled in IDLE; a go while busy is dropped, never queued.
module pi_alu_sequencer #(
    parameter int INT_DEC_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pi_alu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTG  = 3'd1,
        S_ICOMP = 3'd2,
        S_PCOMP = 3'd3,
        S_RHT   = 3'd4,
        S_RHT2  = 3'd5,
        S_LFT   = 3'd6,
        S_LFT2  = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;   // second cycle of the two-cycle multiply steps
    logic [INT_DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [15:0]            error_q, error_d;
    logic [15:0]            intgrl_q, intgrl_d;
    logic [15:0]            icomp_q, icomp_d;
    logic [15:0]            pcomp_q, pcomp_d;
    logic [15:0]            accum_q, accum_d;
    logic [15:0]            rht_q, rht_d;
    logic [15:0]            lft_q, lft_d;
    logic                   done_q, done_d;

    logic [2:0]             src1_sel;
    logic [2:0]             src0_sel;
    logic                   mul_en;
    logic                   sat_en;
    logic                   sub_en;

    // Next-state, register captures and Moore ALU controls decoded from the current step.
    always_comb begin
        state_d   = state_q;
        phase_d   = 1'b0;
        dec_cnt_d = dec_cnt_q;
        error_d   = error_q;
        intgrl_d  = intgrl_q;
        icomp_d   = icomp_q;
        pcomp_d   = pcomp_q;
        accum_d   = accum_q;
        rht_d     = rht_q;
        lft_d     = lft_q;
        done_d    = 1'b0;
        src1_sel  = 3'b000;
        src0_sel  = 3'b000;
        mul_en    = 1'b0;
        sat_en    = 1'b0;
        sub_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    error_d = bus.err_in;
                    state_d = S_INTG;
                end
            end
            S_INTG: begin
                // Integrator only commits once every 2^INT_DEC_W runs.
                src1_sel  = 3'b011;
                src0_sel  = 3'b001;
                sat_en    = 1'b1;
                if (dec_cnt_q == '1) begin
                    intgrl_d = bus.dst;
                end
                dec_cnt_d = dec_cnt_q + 1'b1;
                state_d   = S_ICOMP;
            end
            S_ICOMP: begin
                src1_sel = 3'b001;
                src0_sel = 3'b001;
                mul_en   = 1'b1;
                sat_en   = 1'b1;
                if (phase_q) begin
                    icomp_d = bus.dst;
                    state_d = S_PCOMP;
                end else begin
                    phase_d = 1'b1;
                end
            end
            S_PCOMP: begin
                src1_sel = 3'b010;
                src0_sel = 3'b100;
                mul_en   = 1'b1;
                sat_en   = 1'b1;
                if (phase_q) begin
                    pcomp_d = bus.dst;
                    state_d = S_RHT;
                end else begin
                    phase_d = 1'b1;
                end
            end
            S_RHT: begin
                src1_sel = 3'b100;
                src0_sel = 3'b011;
                sub_en   = 1'b1;
                sat_en   = 1'b1;
                accum_d  = bus.dst;
                state_d  = S_RHT2;
            end
            S_RHT2: begin
                src1_sel = 3'b000;
                src0_sel = 3'b010;
                sub_en   = 1'b1;
                sat_en   = 1'b1;
                rht_d    = bus.dst;
                state_d  = S_LFT;
            end
            S_LFT: begin
                src1_sel = 3'b100;
                src0_sel = 3'b011;
                sat_en   = 1'b1;
                accum_d  = bus.dst;
                state_d  = S_LFT2;
            end
            S_LFT2: begin
                src1_sel = 3'b000;
                src0_sel = 3'b010;
                sat_en   = 1'b1;
                lft_d    = bus.dst;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and PI registers; reset aborts any run in flight without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            dec_cnt_q <= '0;
            error_q   <= '0;
            intgrl_q  <= '0;
            icomp_q   <= '0;
            pcomp_q   <= '0;
            accum_q   <= '0;
            rht_q     <= '0;
            lft_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dec_cnt_q <= dec_cnt_d;
            error_q   <= error_d;
            intgrl_q  <= intgrl_d;
            icomp_q   <= icomp_d;
            pcomp_q   <= pcomp_d;
            accum_q   <= accum_d;
            rht_q     <= rht_d;
            lft_q     <= lft_d;
            done_q    <= done_d;
        end
    end

    assign bus.src1sel  = src1_sel;
    assign bus.src0sel  = src0_sel;
    assign bus.multiply = mul_en;
    assign bus.saturate = sat_en;
    assign bus.sub      = sub_en;
    assign bus.mult2    = 1'b0;
    assign bus.mult4    = 1'b0;
    assign bus.Accum    = accum_q;
    assign bus.Pcomp    = pcomp_q;
    assign bus.Icomp    = icomp_q;
    assign bus.Intgrl   = intgrl_q;
    assign bus.Error    = error_q;
    assign bus.rht      = rht_q;
    assign bus.lft      = lft_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pi_alu_sequencer.sv
// Testbench for pi_alu_sequencer: behavioural ALU + source mux closes the loop on dst,
// and a per-run arithmetic model of the PI update predicts every result.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_pi_alu_sequencer;

    localparam logic [15:0] FWD   = 16'h0400;
    localparam logic [15:0] PTERM = 16'h7FFF;
    localparam logic [15:0] ITERM = 16'h0500;
    localparam int          DEC_W = 2;
    localparam int          DEC_N = 1 << DEC_W;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pi_alu_sequencer_if bus ();

    pi_alu_sequencer #(.INT_DEC_W(DEC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else                 return v[15:0];
    endfunction

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    // Behavioural ALU with its source muxes.
    longint      a1, a0, ar;
    logic [15:0] alu_dst;
    always_comb begin
        a1 = 0;
        a0 = 0;
        case (bus.src1sel)
            3'b000:  a1 = sx(bus.Accum);
            3'b001:  a1 = sx(ITERM);
            3'b010:  a1 = sx(bus.Error);
            3'b011:  a1 = sx(bus.Error) >>> 4;
            3'b100:  a1 = sx(FWD);
            default: a1 = 0;
        endcase
        case (bus.src0sel)
            3'b001:  a0 = sx(bus.Intgrl);
            3'b010:  a0 = sx(bus.Icomp);
            3'b011:  a0 = sx(bus.Pcomp);
            3'b100:  a0 = sx(PTERM);
            default: a0 = 0;
        endcase
        if (bus.multiply)  ar = (a1 * a0) >>> 12;
        else if (bus.sub)  ar = a1 - a0;
        else               ar = a1 + a0;
        alu_dst = bus.saturate ? sat16(ar) : ar[15:0];
    end
    assign bus.dst = alu_dst;

    // Per-run reference model of the PI update.
    int          m_run;
    logic [15:0] m_intg, m_icomp, m_pcomp, m_rht, m_lft;

    task automatic model_reset();
        m_run  = 0;
        m_intg = 16'h0;  m_icomp = 16'h0; m_pcomp = 16'h0;
        m_rht  = 16'h0;  m_lft   = 16'h0;
    endtask

    task automatic model_step(input logic [15:0] e);
        longint ev;
        ev    = sx(e);
        m_run = m_run + 1;
        if (m_run % DEC_N == 0) m_intg = sat16(sx(m_intg) + (ev >>> 4));
        m_icomp = sat16((sx(ITERM) * sx(m_intg)) >>> 12);
        m_pcomp = sat16((ev * sx(PTERM)) >>> 12);
        m_rht   = sat16(sx(sat16(sx(FWD) - sx(m_pcomp))) - sx(m_icomp));
        m_lft   = sat16(sx(sat16(sx(FWD) + sx(m_pcomp))) + sx(m_icomp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bus.go     = 1'b0;
        bus.err_in = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issues one go and waits (bounded) for done; lat = cycles after T0, -1 on timeout.
    task automatic start_and_wait(input logic [15:0] e, output int lat);
        @(negedge clk);
        bus.go     = 1'b1;
        bus.err_in = e;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.go = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0]  ctl;
        logic [111:0] regs;
        rst_n      = 1'b0;
        bus.go     = 1'b0;
        bus.err_in = 16'h0;
        repeat (2) @(negedge clk);
        ctl  = {bus.src1sel, bus.src0sel, bus.multiply, bus.saturate, bus.mult2, bus.mult4, bus.sub, bus.busy, bus.done};
        regs = {bus.Accum, bus.Pcomp, bus.Icomp, bus.Intgrl, bus.Error, bus.rht, bus.lft};
        total++; if (ctl !== 11'h0) begin bad++; $display("FAIL reset_ctl got=%h exp=0", ctl); end
        total++; if (regs !== 112'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs); end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_trace();
        logic [12:0] exp_tab [9];
        logic [12:0] obs;
        exp_tab[0] = {3'b011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[1] = {3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[2] = {3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[3] = {3'b010, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[4] = {3'b010, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[5] = {3'b100, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[6] = {3'b000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[7] = {3'b100, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_tab[8] = {3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        bus.go     = 1'b1;
        bus.err_in = 16'h0000;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            bus.go = 1'b0;
            obs = {bus.src1sel, bus.src0sel, bus.multiply, bus.saturate, bus.sub, bus.mult2, bus.mult4, bus.busy, bus.done};
            total++; if (obs !== exp_tab[k]) begin bad++; $display("FAIL trace_T%0d got=%b exp=%b", k + 1, obs, exp_tab[k]); end
        end
        @(negedge clk);
        total++; if ({bus.done, bus.busy} !== 2'b10) begin bad++; $display("FAIL trace_T10_done_busy got=%b exp=10", {bus.done, bus.busy}); end
        total++; if (bus.rht !== 16'h0400) begin bad++; $display("FAIL trace_rht got=%h exp=0400", bus.rht); end
        total++; if (bus.lft !== 16'h0400) begin bad++; $display("FAIL trace_lft got=%h exp=0400", bus.lft); end
        model_step(16'h0000);
    endtask

    task automatic test_intgrl_decimation();
        int lat;
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            start_and_wait(16'h0100, lat);
            model_step(16'h0100);
            total++; if (lat !== 10) begin bad++; $display("FAIL intg_latency run%0d got=%0d exp=10", r, lat); end
            total++; if (bus.Intgrl !== m_intg) begin bad++; $display("FAIL intg_value run%0d got=%h exp=%h", r, bus.Intgrl, m_intg); end
        end
        total++; if (bus.Intgrl !== 16'h0010) begin bad++; $display("FAIL intg_run4 got=%h exp=0010", bus.Intgrl); end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        for (int r = 1; r <= 8; r++) begin
            start_and_wait(16'h7FFF, lat);
            model_step(16'h7FFF);
            total++; if (bus.Pcomp !== 16'h7FFF) begin bad++; $display("FAIL sat_pcomp run%0d got=%h exp=7fff", r, bus.Pcomp); end
            total++; if ({bus.rht, bus.lft} !== {m_rht, m_lft}) begin bad++; $display("FAIL sat_rht_lft run%0d got=%h exp=%h", r, {bus.rht, bus.lft}, {m_rht, m_lft}); end
        end
        total++; if (bus.rht !== 16'h8000) begin bad++; $display("FAIL sat_rht_neg got=%h exp=8000", bus.rht); end
        total++; if (bus.lft !== 16'h7FFF) begin bad++; $display("FAIL sat_lft_pos got=%h exp=7fff", bus.lft); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e1, e2;
        int dones, lat;
        do_reset();
        e1 = 16'($urandom);
        e2 = 16'($urandom);
        @(negedge clk);
        bus.go     = 1'b1;
        bus.err_in = e1;
        dones = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 3 || k == 6) begin
                bus.go     = 1'b1;
                bus.err_in = 16'($urandom);
            end else begin
                bus.go = 1'b0;
            end
            if (bus.done === 1'b1) dones++;
        end
        @(negedge clk);
        total++; if (dones !== 0) begin bad++; $display("FAIL b2b_early_done got=%0d exp=0", dones); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done_T10 got=%b exp=1", bus.done); end
        model_step(e1);
        total++; if (bus.Error !== e1) begin bad++; $display("FAIL b2b_error_held got=%h exp=%h", bus.Error, e1); end
        total++; if ({bus.rht, bus.lft} !== {m_rht, m_lft}) begin bad++; $display("FAIL b2b_run1 got=%h exp=%h", {bus.rht, bus.lft}, {m_rht, m_lft}); end
        bus.go     = 1'b1;
        bus.err_in = e2;
        @(negedge clk);
        bus.go = 1'b0;
        total++; if ({bus.busy, bus.done} !== 2'b10) begin bad++; $display("FAIL b2b_busy_T11 got=%b exp=10", {bus.busy, bus.done}); end
        lat = -1;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++; if (lat !== 20) begin bad++; $display("FAIL b2b_second_done got=%0d exp=20", lat); end
        model_step(e2);
        total++; if ({bus.rht, bus.lft} !== {m_rht, m_lft}) begin bad++; $display("FAIL b2b_run2 got=%h exp=%h", {bus.rht, bus.lft}, {m_rht, m_lft}); end
    endtask

    task automatic test_reset_mid_run();
        logic [10:0]  ctl;
        logic [111:0] regs;
        int lat, dones, busies;
        do_reset();
        start_and_wait(16'h1234, lat);
        @(negedge clk);
        bus.go     = 1'b1;
        bus.err_in = 16'h2345;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.src1sel !== 3'b010) begin bad++; $display("FAIL midrst_in_pcomp got=%b exp=010", bus.src1sel); end
        #2 rst_n = 1'b0;
        #1;
        ctl  = {bus.src1sel, bus.src0sel, bus.multiply, bus.saturate, bus.mult2, bus.mult4, bus.sub, bus.busy, bus.done};
        regs = {bus.Accum, bus.Pcomp, bus.Icomp, bus.Intgrl, bus.Error, bus.rht, bus.lft};
        total++; if (ctl !== 11'h0) begin bad++; $display("FAIL midrst_ctl got=%h exp=0", ctl); end
        total++; if (regs !== 112'h0) begin bad++; $display("FAIL midrst_regs got=%h exp=0", regs); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        dones  = 0;
        busies = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busies++;
        end
        total++; if ({dones, busies} !== {32'd0, 32'd0}) begin bad++; $display("FAIL midrst_quiet got=%0d/%0d exp=0/0", dones, busies); end
        start_and_wait(16'h0000, lat);
        model_step(16'h0000);
        total++; if (lat !== 10) begin bad++; $display("FAIL midrst_rerun_latency got=%0d exp=10", lat); end
        total++; if ({bus.rht, bus.lft} !== 32'h0400_0400) begin bad++; $display("FAIL midrst_rerun got=%h exp=04000400", {bus.rht, bus.lft}); end
    endtask

    task automatic test_random();
        logic [15:0] e;
        int lat;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0:       e = 16'($urandom);
                1:       e = 16'($signed($urandom_range(0, 511)) - 256);
                2:       e = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                default: e = 16'h0000;
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_and_wait(e, lat);
            model_step(e);
            total++; if (lat !== 10) begin bad++; $display("FAIL rnd_latency run%0d got=%0d exp=10", r, lat); end
            total++; if (bus.Error !== e) begin bad++; $display("FAIL rnd_error run%0d got=%h exp=%h", r, bus.Error, e); end
            total++; if (bus.Intgrl !== m_intg) begin bad++; $display("FAIL rnd_intgrl run%0d got=%h exp=%h", r, bus.Intgrl, m_intg); end
            total++; if (bus.Icomp !== m_icomp) begin bad++; $display("FAIL rnd_icomp run%0d got=%h exp=%h", r, bus.Icomp, m_icomp); end
            total++; if (bus.Pcomp !== m_pcomp) begin bad++; $display("FAIL rnd_pcomp run%0d got=%h exp=%h", r, bus.Pcomp, m_pcomp); end
            total++; if (bus.rht !== m_rht) begin bad++; $display("FAIL rnd_rht run%0d got=%h exp=%h", r, bus.rht, m_rht); end
            total++; if (bus.lft !== m_lft) begin bad++; $display("FAIL rnd_lft run%0d got=%h exp=%h", r, bus.lft, m_lft); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_trace();
        test_intgrl_decimation();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
